// File: rtl/ssc_pkg.sv
// Shared types and constants for the Super Serial Card serial peer.
// Contents: uart_state_t (used by both RX and TX FSMs), oversample and
// data-bit counts, derived counter widths, and the baud divider helper.
package ssc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_TICK_W     = $clog2(UART_OVERSAMPLE);
  localparam int unsigned UART_BIT_W      = $clog2(UART_DATA_BITS);

  // Clocks per oversample tick, integer-truncated.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / (baud * UART_OVERSAMPLE);
  endfunction

endpackage

// File: rtl/ssc_peer_fifo.sv
// Synchronous first-word-fall-through byte FIFO for the serial peer RX path.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i/data_i  write request and byte
//   pop_i          remove head (ignored when empty)
//   data_o         head of queue (registered, 0 after reset)
//   valid_o        queue non-empty (registered)
//   drop_c_o       push refused because the queue stayed full (combinational)
module ssc_peer_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       drop_c_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("ssc_peer_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             empty_c, full_c, pop_ok_c, push_ok_c;

  // Pointer update; a pop frees a slot for a simultaneous push when full.
  always_comb begin
    empty_c   = (wr_ptr_q == rd_ptr_q);
    full_c    = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    pop_ok_c  = pop_i && !empty_c;
    push_ok_c = push_i && (!full_c || pop_ok_c);
    drop_c_o  = push_i && !push_ok_c;
    wr_ptr_d  = wr_ptr_q + PTR_W'(push_ok_c);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop_ok_c);
    valid_d   = (wr_ptr_d != rd_ptr_d);
    // Head bypass: the byte being written becomes the new head.
    if (push_ok_c && (wr_ptr_q[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0])) begin
      data_d = data_i;
    end else begin
      data_d = mem_q[rd_ptr_d[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  // Storage array carries no reset; contents are qualified by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok_c) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ssc_serial_peer.sv
// Far end of the Super Serial Card 8N1 link: receives the 6551 TX stream into
// a buffer and serializes host bytes back into the 6551 RX pin.
// Ports:
//   clk_logic_i, reset_i          clock, asynchronous active-high reset
//   serial_rx_i / serial_tx_o     line from / to the SSC (idle high)
//   tx_data_i/tx_valid_i/tx_ready_o   byte hand-over to the serializer
//   rx_data_o/rx_valid_o/rx_ready_i   FWFT receive buffer head and pop
//   rx_overrun_o, rx_frame_err_o  sticky error flags, cleared by clear_err_i
// Build option: SSC_PEER_RX_FIFO_EN selects the RX_FIFO_DEPTH-entry FIFO;
// otherwise a single holding register buffers received bytes.
module ssc_serial_peer
  import ssc_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED_HZ = 54_000_000,
  parameter int unsigned BAUD_RATE      = 9600,
  parameter int unsigned RX_FIFO_DEPTH  = 16
) (
  input  logic       clk_logic_i,
  input  logic       reset_i,
  input  logic       serial_rx_i,
  output logic       serial_tx_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_overrun_o,
  output logic       rx_frame_err_o,
  input  logic       clear_err_i
);

  localparam int unsigned DIV   = uart_div(CLOCK_SPEED_HZ, BAUD_RATE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0]       DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [UART_TICK_W-1:0] TICK_LAST = UART_TICK_W'(UART_OVERSAMPLE - 1);
  localparam logic [UART_TICK_W-1:0] TICK_MID  = UART_TICK_W'(UART_OVERSAMPLE / 2 - 1);
  localparam logic [UART_BIT_W-1:0]  BIT_LAST  = UART_BIT_W'(UART_DATA_BITS - 1);

  if (DIV == 0) begin : g_div_check
    $error("ssc_serial_peer: CLOCK_SPEED_HZ too low for BAUD_RATE");
  end

  // ---------------- RX ----------------
  logic                      rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_t               rx_state_q, rx_state_d;
  logic [DIV_W-1:0]          rx_div_q, rx_div_d;
  logic [UART_TICK_W-1:0]    rx_tick_q, rx_tick_d;
  logic [UART_BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [UART_DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                      rx_brk_q, rx_brk_d;
  logic                      rx_os_c, rx_push_c, rx_ferr_c, rx_drop_c;

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= serial_rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      rx_state_q <= IDLE;
      rx_div_q   <= '0;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_brk_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_brk_q   <= rx_brk_d;
    end
  end

  // RX next state; the oversample divider restarts on each start edge so the
  // mid-bit sample points are phase-locked to the incoming frame.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_brk_d   = rx_brk_q;
    rx_push_c  = 1'b0;
    rx_ferr_c  = 1'b0;
    rx_os_c    = (rx_div_q == DIV_LAST);

    if (rx_state_q != IDLE) begin
      rx_div_d = rx_os_c ? '0 : rx_div_q + DIV_W'(1);
      if (rx_os_c) begin
        rx_tick_d = rx_tick_q + UART_TICK_W'(1);
      end
    end

    unique case (rx_state_q)
      IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = START;
          rx_div_d   = '0;
          rx_tick_d  = '0;
        end
      end
      START: begin
        if (rx_os_c && rx_tick_q == TICK_MID) begin
          rx_tick_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_os_c && rx_tick_q == TICK_LAST) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[UART_DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + UART_BIT_W'(1);
          if (rx_bit_q == BIT_LAST) begin
            rx_state_d = STOP;
          end
        end
      end
      STOP: begin
        if (rx_brk_q) begin
          // Bad stop bit: hold off until the line is released.
          if (rx_sync_q) begin
            rx_brk_d   = 1'b0;
            rx_state_d = IDLE;
          end
        end else if (rx_os_c && rx_tick_q == TICK_LAST) begin
          if (rx_sync_q) begin
            rx_push_c  = 1'b1;
            rx_state_d = IDLE;
          end else begin
            rx_ferr_c = 1'b1;
            rx_brk_d  = 1'b1;
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // ---------------- receive buffer ----------------
`ifdef SSC_PEER_RX_FIFO_EN
  ssc_peer_fifo #(
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i    (clk_logic_i),
    .rst_i    (reset_i),
    .push_i   (rx_push_c),
    .data_i   (rx_shift_q),
    .pop_i    (rx_ready_i),
    .data_o   (rx_data_o),
    .valid_o  (rx_valid_o),
    .drop_c_o (rx_drop_c)
  );
`else
  // Depth has no meaning for the single holding register.
  if (RX_FIFO_DEPTH == 0) begin : g_depth_ignored
  end

  logic [7:0] hold_data_q;
  logic       hold_valid_q;
  logic       hold_pop_c, hold_push_ok_c;

  always_comb begin
    hold_pop_c     = rx_ready_i && hold_valid_q;
    hold_push_ok_c = rx_push_c && (!hold_valid_q || hold_pop_c);
    rx_drop_c      = rx_push_c && !hold_push_ok_c;
  end

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
    end else if (hold_push_ok_c) begin
      hold_data_q  <= rx_shift_q;
      hold_valid_q <= 1'b1;
    end else if (hold_pop_c) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign rx_data_o  = hold_data_q;
  assign rx_valid_o = hold_valid_q;
`endif

  // Sticky flags; a new event in the clearing cycle keeps the flag set.
  logic ovr_q, ferr_q;

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= rx_drop_c | (ovr_q & ~clear_err_i);
      ferr_q <= rx_ferr_c | (ferr_q & ~clear_err_i);
    end
  end

  assign rx_overrun_o   = ovr_q;
  assign rx_frame_err_o = ferr_q;

  // ---------------- TX ----------------
  uart_state_t               tx_state_q, tx_state_d;
  logic [DIV_W-1:0]          tx_div_q, tx_div_d;
  logic [UART_TICK_W-1:0]    tx_tick_q, tx_tick_d;
  logic [UART_BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [UART_DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                      tx_line_q, tx_line_d;
  logic                      tx_ready_q, tx_ready_d;
  logic                      tx_os_c;

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      tx_state_q <= IDLE;
      tx_div_q   <= '0;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // TX next state; each line level is held for a full 16-tick bit period.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_os_c    = (tx_div_q == DIV_LAST);

    if (tx_state_q != IDLE) begin
      tx_div_d = tx_os_c ? '0 : tx_div_q + DIV_W'(1);
      if (tx_os_c) begin
        tx_tick_d = tx_tick_q + UART_TICK_W'(1);
      end
    end

    unique case (tx_state_q)
      IDLE: begin
        tx_line_d = 1'b1;
        if (tx_valid_i) begin
          tx_state_d = START;
          tx_div_d   = '0;
          tx_tick_d  = '0;
          tx_shift_d = tx_data_i;
          tx_line_d  = 1'b0;
        end
      end
      START: begin
        if (tx_os_c && tx_tick_q == TICK_LAST) begin
          tx_state_d = DATA;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
        end
      end
      DATA: begin
        if (tx_os_c && tx_tick_q == TICK_LAST) begin
          tx_shift_d = {1'b0, tx_shift_q[UART_DATA_BITS-1:1]};
          tx_bit_d   = tx_bit_q + UART_BIT_W'(1);
          if (tx_bit_q == BIT_LAST) begin
            tx_state_d = STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_line_d = tx_shift_q[1];
          end
        end
      end
      STOP: begin
        if (tx_os_c && tx_tick_q == TICK_LAST) begin
          tx_state_d = IDLE;
        end
      end
      default: tx_state_d = IDLE;
    endcase

    tx_ready_d = (tx_state_d == IDLE);
  end

  assign serial_tx_o = tx_line_q;
  assign tx_ready_o  = tx_ready_q;

endmodule

// File: tb/tb_ssc_serial_peer.sv
// Self-checking bench for ssc_serial_peer, run at a fast baud rate
// (2 clocks per oversample tick, 32 clocks per bit). Received bytes are
// tracked by a capacity-limited queue model; transmitted frames are compared
// bit by bit against the 8N1 framing of the supplied byte.
module tb_ssc_serial_peer;

  localparam int unsigned CLK_HZ   = 1_000_000;
  localparam int unsigned BAUD     = 31_250;
  localparam int unsigned DIVC     = CLK_HZ / (BAUD * 16);
  localparam int unsigned BIT_CLKS = DIVC * 16;
`ifdef SSC_PEER_RX_FIFO_EN
  localparam int unsigned CAP = 16;
`else
  localparam int unsigned CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_drv, loop_en, rx_line;
  logic       serial_tx;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       ovr, ferr, clr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovr, exp_ferr;

  assign rx_line = loop_en ? serial_tx : rx_drv;

  always #5 clk = ~clk;

  ssc_serial_peer #(
    .CLOCK_SPEED_HZ (CLK_HZ),
    .BAUD_RATE      (BAUD),
    .RX_FIFO_DEPTH  (16)
  ) dut (
    .clk_logic_i    (clk),
    .reset_i        (rst),
    .serial_rx_i    (rx_line),
    .serial_tx_o    (serial_tx),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_ready_i     (rx_ready),
    .rx_overrun_o   (ovr),
    .rx_frame_err_o (ferr),
    .clear_err_i    (clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() < CAP) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  // Drive one 8N1 frame on the RX line (stop bit selectable), then release.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    send_frame(b, stop);
    repeat (BIT_CLKS) @(posedge clk);
    #1;
    if (stop) model_push(b);
    else exp_ferr = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    step();
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_empty"}, rx_valid, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, rx_valid, 1);
      check({tag, "_data"}, rx_data, e);
      step();
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
    end
  endtask

  task automatic drain_check(input string tag);
    while (exp_q.size() > 0) pop_check(tag);
    @(negedge clk);
    check({tag, "_drained"}, rx_valid, 0);
  endtask

  task automatic clear_flags();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
    @(negedge clk);
    check("clr_ovr", ovr, 0);
    check("clr_ferr", ferr, 0);
  endtask

  // Hand a byte to the serializer and check every bit at mid-period.
  task automatic tx_send(input logic [7:0] b);
    logic [9:0] fr;
    int c;
    fr = {1'b1, b, 1'b0};
    step();
    c = 0;
    while (!tx_ready && c < 20 * BIT_CLKS) begin
      step();
      c++;
    end
    check("tx_ready_wait", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? BIT_CLKS / 2 : BIT_CLKS) @(negedge clk);
      check($sformatf("tx_bit%0d_%02h", k, b), serial_tx, fr[k]);
      check("tx_busy", tx_ready, 0);
    end
    c = 0;
    while (!tx_ready && c < 4 * BIT_CLKS) begin
      @(negedge clk);
      c++;
    end
    c = c + BIT_CLKS / 2 + 9 * BIT_CLKS;
    check("tx_ready_return", (c >= 10 * BIT_CLKS + 1) && (c <= 10 * BIT_CLKS + 2), 1);
  endtask

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         lat;
    logic [7:0] b;
    logic       st;

    rst = 1'b1; rx_drv = 1'b1; loop_en = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; clr = 1'b0;
    exp_ovr = 1'b0; exp_ferr = 1'b0;
    lat = 0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_line", serial_tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_ovr", ovr, 0);
    check("rst_ferr", ferr, 0);
    step();
    rst = 1'b0;
    repeat (4) step();

    // Receive 0x41 and measure when it becomes visible.
    fork
      send_frame(8'h41, 1'b1);
      begin
        while (!rx_valid && lat < 12 * BIT_CLKS) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("rx_latency", (lat >= BIT_CLKS * 19 / 2) && (lat <= BIT_CLKS * 19 / 2 + 8), 1);
    model_push(8'h41);
    pop_check("rx41");
    @(negedge clk);
    check("rx41_popped", rx_valid, 0);

    // Transmit 0xA5 and a few random bytes.
    tx_send(8'hA5);
    for (int i = 0; i < 2; i++) tx_send(8'($urandom));

    // Framing error: no push, sticky flag, cleared on request.
    step();
    rx_frame(8'h55, 1'b0);
    @(negedge clk);
    check("ferr_set", ferr, exp_ferr);
    check("ferr_no_push", rx_valid, 0);
    clear_flags();

    // Random frames, random pops, occasional bad stop bits.
    for (int i = 0; i < 6; i++) begin
      b  = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      rx_frame(b, st);
      if ($urandom_range(0, 1) == 1) drain_check("rnd");
    end
    @(negedge clk);
    check("rnd_ovr", ovr, exp_ovr);
    check("rnd_ferr", ferr, exp_ferr);
    drain_check("rnd_end");
    clear_flags();

    // Overrun: 17 frames with no pops.
    step();
    for (int i = 0; i < 17; i++) begin
      rx_frame(8'($urandom), 1'b1);
      if (i == int'(CAP) - 1) begin
        @(negedge clk);
        check("ovr_at_full", ovr, 0);
        step();
      end
    end
    @(negedge clk);
    check("ovr_set", ovr, exp_ovr);
    check("ovr_expected", exp_ovr, 1);
    drain_check("ovr");
    clear_flags();

    // Short low glitch produces nothing.
    step();
    rx_drv = 1'b0;
    repeat (3 * DIVC) step();
    rx_drv = 1'b1;
    repeat (2 * BIT_CLKS) step();
    @(negedge clk);
    check("glitch_no_byte", rx_valid, 0);
    check("glitch_no_ferr", ferr, 0);

    // Reset mid-frame in both directions, with a byte already buffered.
    step();
    rx_frame(8'($urandom), 1'b1);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    rx_drv   = 1'b0;
    repeat (3 * BIT_CLKS) @(posedge clk);
    #3;
    check("pre_rst_tx_low", serial_tx, 0);
    rst = 1'b1;
    #1;
    check("async_rst_tx_line", serial_tx, 1);
    check("async_rst_tx_ready", tx_ready, 1);
    check("async_rst_rx_valid", rx_valid, 0);
    check("async_rst_rx_data", rx_data, 0);
    step();
    rx_drv = 1'b1;
    rst    = 1'b0;
    exp_q.delete();
    repeat (4) step();

    // Loopback.
    loop_en = 1'b1;
    tx_send(8'h00); model_push(8'h00); pop_check("loop00");
    tx_send(8'hFF); model_push(8'hFF); pop_check("loopff");
    tx_send(8'h3C); model_push(8'h3C); pop_check("loop3c");
    @(negedge clk);
    check("loop_ovr", ovr, 0);
    check("loop_ferr", ferr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ssc_serial_peer.md
# ssc_serial_peer

In-fabric far end of the Super Serial Card's serial link. It deserializes the 8N1 stream the SSC's 6551 transmits, buffers the received bytes, and serializes host-supplied bytes back into the 6551's receive pin. It sits between the SSC `uart_tx_o`/`uart_rx_i` pins and an internal consumer/producer such as an overlay console or USB bridge, replacing an external RS-232 terminal.

## Interface
- `CLOCK_SPEED_HZ`, 54_000_000, frequency of `clk_logic_i`.
- `BAUD_RATE`, 9600, line rate; matches the SSC default DIP setting.
- `RX_FIFO_DEPTH`, 16, receive buffer entries; must be a power of 2 and at least 2.
- `clk_logic_i`  in  1  system logic clock; the only clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `serial_rx_i`  in  1  line from the SSC `uart_tx_o`; asynchronous to the clock.
- `serial_tx_o`  out  1  line to the SSC `uart_rx_i`; idles at 1.
- `tx_data_i`  in  8  byte to send.
- `tx_valid_i`  in  1  `tx_data_i` is valid.
- `tx_ready_o`  out  1  serializer idle; a byte is accepted when `tx_valid_i` and `tx_ready_o` are both high.
- `rx_data_o`  out  8  head of the receive buffer.
- `rx_valid_o`  out  1  receive buffer is non-empty.
- `rx_ready_i`  in  1  pop the head when `rx_valid_o` is also high.
- `rx_overrun_o`  out  1  sticky: a byte was dropped because the buffer was full.
- `rx_frame_err_o`  out  1  sticky: a frame had a stop bit of 0.
- `clear_err_i`  in  1  clears both sticky flags.

## Operation
- **Tick generator.** A 16× oversample tick fires every `DIV = CLOCK_SPEED_HZ / (BAUD_RATE*16)` clocks, using integer truncation. The default is 351, so one bit period is 5616 clocks. Elaboration fails if `DIV` is 0.
- **RX input.** `serial_rx_i` passes through a 2-flop synchronizer before any use.
- **RX state machine: IDLE → START → DATA → STOP → IDLE.**
  - IDLE: a synchronized 1→0 transition enters START and resets the tick counter.
  - START: at tick 8 the line is resampled. If it is high, the start bit was a glitch and the FSM returns to IDLE. If it is low, the FSM enters DATA.
  - DATA: 8 bits are sampled every 16 ticks, at mid-bit, LSB first.
  - STOP: the stop bit is sampled at mid-bit.
    - Stop = 1: the byte is pushed to the buffer.
    - Stop = 0: `rx_frame_err_o` is set, the byte is discarded, and the FSM waits for the line to return high before re-entering IDLE.
- **TX state machine: IDLE → START → DATA → STOP → IDLE.**
  - `tx_ready_o` is 1 only in IDLE.
  - On acceptance the byte is latched, then the FSM drives the start bit 0, 8 data bits LSB first, and stop bit 1, each for 16 ticks.
  - `tx_data_i` is ignored while the FSM is busy.
- **Receive buffer.** First-word-fall-through; `rx_data_o` is valid whenever `rx_valid_o` is high.
  - Read and write pointers carry one extra wrap bit. The buffer is full when the indices match and the wrap bits differ, and empty when the pointers are equal.
  - Push when full: the byte is dropped and `rx_overrun_o` is set.
  - Push and pop in the same cycle when full: the pop frees a slot, the push is accepted, and no overrun is flagged.
  - Push and pop in the same cycle when empty: the pop is ignored because `rx_valid_o` is 0, and the push is accepted.
- **Error flags.** If `clear_err_i` coincides with a new error event, the flag ends the cycle set (set wins).

## Timing
- **Reset values:**
  - `serial_tx_o` = 1, `tx_ready_o` = 1.
  - `rx_valid_o` = 0, `rx_data_o` = 0x00.
  - `rx_overrun_o` = 0, `rx_frame_err_o` = 0.
  - Both FSMs in IDLE, tick counter at 0.
- **Reset mid-frame.** Any partial frame in either direction is abandoned and the buffer is emptied. `serial_tx_o` returns to 1 asynchronously.
- **RX latency.** `rx_valid_o` rises 1 clock after the mid-stop-bit sample, which is about 9.5 bit periods after the start edge plus 2 synchronizer clocks.
- **TX handshake.** `serial_tx_o` goes to 0 on the clock after acceptance. `tx_ready_o` rises on the clock after the stop bit's 16th tick, so back-to-back bytes have no idle gap beyond 1 clock.
- **Frame budget.** One frame is 10 bit periods, 56160 clocks at the defaults.

## Configuration
- `SSC_PEER_RX_FIFO_EN`
  - Defined: the receive buffer is the `RX_FIFO_DEPTH`-entry FIFO described above.
  - Undefined: the buffer is a single holding register and `RX_FIFO_DEPTH` is ignored. The register is full while `rx_valid_o` is high. A second byte arriving before the pop is dropped and sets `rx_overrun_o`. A pop and a push in the same cycle are both honoured.

## Structure
- `ssc_pkg` holds:
  - the `uart_state_t` enum (IDLE, START, DATA, STOP), shared by both FSMs;
  - `UART_OVERSAMPLE = 16`;
  - `UART_DATA_BITS = 8`.
- One sub-module, `ssc_peer_fifo`: the synchronous first-word-fall-through FIFO, instantiated only when `SSC_PEER_RX_FIFO_EN` is defined.
- The tick generator and both FSMs live in `ssc_serial_peer`.

## Test plan
- **Reset:** hold `reset_i` high for 3 clocks → `serial_tx_o` = 1, `tx_ready_o` = 1, `rx_valid_o` = 0, both flags 0.
- **Receive:** drive an 8N1 frame of 0x41 at 5616 clocks/bit on `serial_rx_i` → `rx_valid_o` rises 1 clock after the mid-stop sample with `rx_data_o` = 0x41. Pulse `rx_ready_i` → `rx_valid_o` = 0.
- **Transmit:** hand over 0xA5 → `serial_tx_o` shows 0,1,0,1,0,0,1,0,1,1, each held 5616 clocks. `tx_ready_o` = 0 throughout and returns to 1 after the stop bit.
- **Framing error:** send a frame of 0x55 with stop bit = 0 → `rx_frame_err_o` = 1, no push. Pulse `clear_err_i` → flag = 0.
- **Overrun:** with `rx_ready_i` = 0, send 17 frames → with the macro defined, 16 are stored and the 17th sets `rx_overrun_o`; with the macro undefined, the 2nd frame sets `rx_overrun_o` and the 1st is retained.
- **Glitch and loopback:** a 3-tick low pulse on `serial_rx_i` produces no byte. Then wire `serial_tx_o` to `serial_rx_i` and send 0x00, 0xFF, 0x3C → the same 3 bytes are received in order.
